// File: rtl/posit_pkg.sv
// Shared posit format definitions and the decode-arbiter state encoding.
// Every supported format carries at least one exponent bit.
package posit_pkg;

    typedef enum logic [1:0] {
        POSIT16_ES1 = 2'd0,
        POSIT8_ES2  = 2'd1,
        POSIT32_ES2 = 2'd2
    } posit_format_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        DONE   = 2'd2
    } decode_state_e;

    function automatic int posit_width(posit_format_e fmt);
        case (fmt)
            POSIT8_ES2:  return 8;
            POSIT32_ES2: return 32;
            default:     return 16;
        endcase
    endfunction

    function automatic int exp_bits(posit_format_e fmt);
        case (fmt)
            POSIT8_ES2:  return 2;
            POSIT32_ES2: return 2;
            default:     return 1;
        endcase
    endfunction

endpackage

// File: rtl/posit_extraction.sv
// Purely combinational posit field extraction: sign, regime k, exponent,
// mantissa with hidden bit, plus NaR and zero flags.
module posit_extraction #(
    parameter  int N  = 16,
    parameter  int ES = 1,
    localparam int RS = $clog2(N)
) (
    input  logic [N-1:0]        operand,
    output logic                sign,
    output logic signed [RS:0]  k,
    output logic [ES-1:0]       exp,
    output logic [N-1:0]        mant,
    output logic                nar,
    output logic                zero
);

    localparam int            W      = N - 1 + ES;
    localparam logic [RS:0]   One    = {{RS{1'b0}}, 1'b1};
    localparam logic [N-2:0]  RemOne = {{(N-2){1'b0}}, 1'b1};

    logic [N-2:0] rem;
    logic [RS:0]  run;
    logic [RS:0]  k_raw;
    logic         ended;
    logic [W-1:0] shifted;

    always_comb begin
        sign  = operand[N-1];
        zero  = (operand == '0);
        nar   = (operand == {1'b1, {(N-1){1'b0}}});
        rem   = sign ? (~operand[N-2:0] + RemOne) : operand[N-2:0];
        run   = '0;
        ended = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!ended && (rem[i] == rem[N-2])) run = run + One;
            else                                ended = 1'b1;
        end
        k_raw = rem[N-2] ? (run - One) : (~run + One);
        k     = zero ? '0 : $signed(k_raw);
        // Drop the regime run and its terminator; exponent then fraction follow.
        shifted = {rem, {ES{1'b0}}} << (run + One);
        exp     = zero ? '0 : shifted[W-1 -: ES];
        mant    = zero ? '0 : {1'b1, shifted[N-2:0]};
    end

endmodule

// File: rtl/posit_decode_arbiter.sv
// Round-robin arbiter in front of a registered posit decoder.
// state  | meaning
// IDLE   | waiting for any requester; grants on the same cycle
// DECODE | latched operand is decoded into the output registers
// DONE   | result valid; held until accepted, may re-grant back-to-back
module posit_decode_arbiter
    import posit_pkg::*;
#(
    parameter  posit_format_e pFormat = posit_format_e'(0),
    parameter  int            NumReq  = 2,
    localparam int            N       = posit_width(pFormat),
    localparam int            ES      = exp_bits(pFormat),
    localparam int            RS      = $clog2(N),
    localparam int            IdW     = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumReq-1:0]     req_valid_i,
    input  logic [NumReq*N-1:0]   req_operand_i,
    output logic [NumReq-1:0]     req_ready_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [IdW-1:0]        out_id_o,
    output logic                  out_sign_o,
    output logic signed [RS:0]    out_k_o,
    output logic [ES-1:0]         out_exp_o,
    output logic [N-1:0]          out_mant_o,
    output logic                  out_nar_o,
    output logic                  out_zero_o,
    output logic                  busy_o
);

    decode_state_e state_q, state_d;

    logic [IdW-1:0] rr_q, rr_next;
    logic [IdW-1:0] win, id_q;
    logic [N-1:0]   op_q;
    logic           any_valid, grant, load_out;
    int             idx;

    logic                 dec_sign, dec_nar, dec_zero;
    logic signed [RS:0]   dec_k;
    logic [ES-1:0]        dec_exp;
    logic [N-1:0]         dec_mant;

    always_comb begin
        any_valid = 1'b0;
        win       = '0;
        idx       = 0;
        for (int i = 0; i < NumReq; i++) begin
            idx = (int'(rr_q) + i) % NumReq;
            if (!any_valid && req_valid_i[idx]) begin
                any_valid = 1'b1;
                win       = IdW'(idx);
            end
        end
        rr_next = IdW'((int'(win) + 1) % NumReq);
    end

    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        load_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                load_out = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready_i) begin
                    grant   = any_valid;
                    state_d = any_valid ? DECODE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gate with reset so no grant is ever advertised while reset is held.
    assign req_ready_o = (grant && rst_ni) ? ({{(NumReq-1){1'b0}}, 1'b1} << win) : '0;
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            op_q       <= '0;
            id_q       <= '0;
            out_id_o   <= '0;
            out_sign_o <= 1'b0;
            out_k_o    <= '0;
            out_exp_o  <= '0;
            out_mant_o <= '0;
            out_nar_o  <= 1'b0;
            out_zero_o <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                op_q <= req_operand_i[int'(win)*N +: N];
                id_q <= win;
                rr_q <= rr_next;
            end
            if (load_out) begin
                out_id_o   <= id_q;
                out_sign_o <= dec_sign;
                out_k_o    <= dec_k;
                out_exp_o  <= dec_exp;
                out_mant_o <= dec_mant;
                out_nar_o  <= dec_nar;
                out_zero_o <= dec_zero;
            end
        end
    end

    posit_extraction #(.N(N), .ES(ES)) u_extract (
        .operand (op_q),
        .sign    (dec_sign),
        .k       (dec_k),
        .exp     (dec_exp),
        .mant    (dec_mant),
        .nar     (dec_nar),
        .zero    (dec_zero)
    );

endmodule

// File: tb/tb_posit_decode_arbiter.sv
// Directed bench for posit_decode_arbiter with 16-bit, ES=1 posits and two requesters.
module tb_posit_decode_arbiter;
    import posit_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        valid;
    logic [31:0]       ops;
    logic [1:0]        ready;
    logic              out_valid;
    logic              out_ready;
    logic [0:0]        out_id;
    logic              out_sign;
    logic signed [4:0] out_k;
    logic [0:0]        out_exp;
    logic [15:0]       out_mant;
    logic              out_nar;
    logic              out_zero;
    logic              busy;
    logic              eid;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    posit_decode_arbiter #(.pFormat(POSIT16_ES1), .NumReq(2)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (valid),
        .req_operand_i (ops),
        .req_ready_o   (ready),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_id_o      (out_id),
        .out_sign_o    (out_sign),
        .out_k_o       (out_k),
        .out_exp_o     (out_exp),
        .out_mant_o    (out_mant),
        .out_nar_o     (out_nar),
        .out_zero_o    (out_zero),
        .busy_o        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One requester alone: grant, decode cycle, then check the held result.
    task automatic single(input int id, input logic [15:0] op, input logic full,
                          input logic s, input logic [4:0] ek, input logic ee,
                          input logic [15:0] em, input logic en, input logic ez);
        valid = (id == 0) ? 2'b01 : 2'b10;
        ops[id*16 +: 16] = op;
        #1;
        chk("single_grant", {30'd0, ready}, (id == 0) ? 32'h1 : 32'h2);
        tick();
        valid = 2'b00;
        #1;
        chk("single_decode_valid", {31'd0, out_valid}, 32'h0);
        chk("single_decode_busy", {31'd0, busy}, 32'h1);
        tick();
        chk("single_out_valid", {31'd0, out_valid}, 32'h1);
        chk("single_id", {31'd0, out_id}, 32'(id));
        chk("single_sign", {31'd0, out_sign}, {31'd0, s});
        chk("single_nar", {31'd0, out_nar}, {31'd0, en});
        chk("single_zero", {31'd0, out_zero}, {31'd0, ez});
        if (full) begin
            chk("single_k", {27'd0, out_k}, {27'd0, ek});
            chk("single_exp", {31'd0, out_exp}, {31'd0, ee});
            chk("single_mant", {16'd0, out_mant}, {16'd0, em});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_idle_busy", {31'd0, busy}, 32'h0);
        chk("single_idle_valid", {31'd0, out_valid}, 32'h0);
    endtask

    initial begin
        rst_n     = 1'b0;
        valid     = 2'b00;
        ops       = 32'h0;
        out_ready = 1'b0;
        #3;
        valid = 2'b11;
        #1;
        chk("rst_ready", {30'd0, ready}, 32'h0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_mant", {16'd0, out_mant}, 32'h0);
        chk("rst_k", {27'd0, out_k}, 32'h0);
        valid = 2'b00;
        #8;
        rst_n = 1'b1;
        tick();

        // id, operand, full, sign, k, exp, mant, nar, zero
        single(0, 16'h4000, 1'b1, 1'b0, 5'h00, 1'b0, 16'h8000, 1'b0, 1'b0);
        single(1, 16'h5000, 1'b1, 1'b0, 5'h00, 1'b1, 16'h8000, 1'b0, 1'b0);
        single(1, 16'h8000, 1'b0, 1'b1, 5'h00, 1'b0, 16'h0000, 1'b1, 1'b0);
        single(0, 16'h0000, 1'b1, 1'b0, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
        single(1, 16'h3800, 1'b1, 1'b0, 5'h1F, 1'b1, 16'hC000, 1'b0, 1'b0);
        single(0, 16'hC000, 1'b1, 1'b1, 5'h00, 1'b0, 16'h8000, 1'b0, 1'b0);
        single(0, 16'h7000, 1'b1, 1'b0, 5'h02, 1'b0, 16'h8000, 1'b0, 1'b0);

        // Last grant went to 0, so the pointer sits at 1: expect 1,0,1,0.
        ops       = {16'h5000, 16'h4000};
        valid     = 2'b11;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            eid = (i % 2 == 0);
            #1;
            chk("rr_grant", {30'd0, ready}, eid ? 32'h2 : 32'h1);
            tick();
            chk("rr_decode_valid", {31'd0, out_valid}, 32'h0);
            chk("rr_decode_ready", {30'd0, ready}, 32'h0);
            tick();
            chk("rr_out_valid", {31'd0, out_valid}, 32'h1);
            chk("rr_id", {31'd0, out_id}, {31'd0, eid});
            chk("rr_exp", {31'd0, out_exp}, {31'd0, eid});
        end

        out_ready = 1'b0;
        ops[15:0] = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_ready", {30'd0, ready}, 32'h0);
            chk("stall_valid", {31'd0, out_valid}, 32'h1);
            chk("stall_id", {31'd0, out_id}, 32'h0);
            chk("stall_mant", {16'd0, out_mant}, 32'h8000);
            chk("stall_zero", {31'd0, out_zero}, 32'h0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("release_grant", {30'd0, ready}, 32'h2);
        tick();
        tick();
        chk("release_valid", {31'd0, out_valid}, 32'h1);
        chk("release_id", {31'd0, out_id}, 32'h1);
        chk("release_exp", {31'd0, out_exp}, 32'h1);
        valid = 2'b00;
        tick();
        chk("release_idle", {31'd0, busy}, 32'h0);

        // Pointer is now 0; grant 0 moves it to 1, reset must return it to 0.
        out_ready = 1'b0;
        valid     = 2'b01;
        ops[15:0] = 16'h4000;
        #1;
        chk("pre_rst_grant", {30'd0, ready}, 32'h1);
        tick();
        valid = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'h0);
        chk("mid_rst_busy", {31'd0, busy}, 32'h0);
        chk("mid_rst_mant", {16'd0, out_mant}, 32'h0);
        chk("mid_rst_exp", {31'd0, out_exp}, 32'h0);
        chk("mid_rst_id", {31'd0, out_id}, 32'h0);
        chk("mid_rst_ready", {30'd0, ready}, 32'h0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_no_valid", {31'd0, out_valid}, 32'h0);
            chk("post_rst_idle", {31'd0, busy}, 32'h0);
        end
        valid = 2'b11;
        #1;
        chk("post_rst_rr", {30'd0, ready}, 32'h1);
        out_ready = 1'b1;
        tick();
        valid = 2'b00;
        tick();
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'h1);
        chk("post_rst_id", {31'd0, out_id}, 32'h0);
        chk("post_rst_mant", {16'd0, out_mant}, 32'h8000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
